vga_frame_sink: RTL and testbench

- Receiving end of the pixel-plot interface driven by the screen drawers, which emit column/row/colour plus a plot strobe.
- Converts each plot into a linear write into an external dual-port 160x120x9 frame buffer.
- Independently scans that buffer out as 640x480@60 VGA, upscaled 4x in each axis.
- Sits between the game drawing logic and the board VGA DAC pins.

---
 rtl/vga_frame_sink_if.sv | 17 +
 rtl/vga_frame_sink.sv | 196 +++++++++++++++++++
 tb/tb_vga_frame_sink.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_sink_if.sv
// vga_frame_sink_if
//   Pixel-plot bus between the screen drawers and the frame sink.
//   Signals:
//     plot   - write strobe, one pixel per clk while high
//     column - x coordinate (0..159 in range)
//     row    - y coordinate (0..119 in range)
//     colour - 9-bit RGB333, R in the MSBs
//   Modports: master (drawer side drives), slave (sink side receives).
interface vga_frame_sink_if;
    logic       plot;
    logic [7:0] column;
    logic [6:0] row;
    logic [8:0] colour;

    modport master (output plot, column, row, colour);
    modport slave  (input  plot, column, row, colour);
endinterface

// File: rtl/vga_frame_sink.sv
// vga_frame_sink
//   Turns drawer plots into linear writes of a 160x120x9 dual-port frame
//   buffer and scans that buffer out as 640x480@60 VGA, upscaled 4x per axis.
//   Optional feature (macro VGA_SINK_CLIP_CNT_EN): clip_cnt, a saturating
//   count of out-of-range plots, cleared on reset and at each frame start.
//   Ports:
//     clk, resetn          - system clock, async active-low reset
//     pix (slave)          - plot/column/row/colour from the drawers
//     wr_addr/wr_data/wr_en- frame buffer write port (1 clk after the plot)
//     rd_addr/rd_data      - frame buffer read port (sync RAM, 1 clk latency)
//     vga_r/g/b            - 8-bit DAC channels, 0 while blanked
//     vga_hs/vga_vs        - active-low syncs
//     vga_blank_n          - low outside the visible area
//     frame_start          - 1-clk pulse when the scan wraps to (0,0)
//     clip_cnt             - only with VGA_SINK_CLIP_CNT_EN
//   The VGA timing parameters default to 640x480@60 and exist so a
//   reduced raster can be elaborated.
module vga_frame_sink #(
    parameter int H_RES        = 160,
    parameter int V_RES        = 120,
    parameter int COLOUR_W     = 9,
    parameter int CLK_DIV      = 2,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 525
) (
    input  logic                clk,
    input  logic                resetn,
    vga_frame_sink_if.slave     pix,
    output logic [14:0]         wr_addr,
    output logic [COLOUR_W-1:0] wr_data,
    output logic                wr_en,
    output logic [14:0]         rd_addr,
    input  logic [COLOUR_W-1:0] rd_data,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                frame_start
`ifdef VGA_SINK_CLIP_CNT_EN
    ,
    output logic [7:0]          clip_cnt
`endif
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]      H_RES_C  = 8'(H_RES);
    localparam logic [6:0]      V_RES_C  = 7'(V_RES);
    localparam logic [9:0]      H_VIS_C  = 10'(H_VISIBLE);
    localparam logic [9:0]      H_SS_C   = 10'(H_SYNC_START);
    localparam logic [9:0]      H_SE_C   = 10'(H_SYNC_END);
    localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_VIS_C  = 10'(V_VISIBLE);
    localparam logic [9:0]      V_SS_C   = 10'(V_SYNC_START);
    localparam logic [9:0]      V_SE_C   = 10'(V_SYNC_END);
    localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);

    // 3-bit field to 8-bit channel by bit replication, so 7 -> FF and 0 -> 00.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       h, v;
    logic             frame_wrap;
    logic             in_range;
    logic [14:0]      plot_addr;
    logic             visible, hs_raw, vs_raw;
    logic             vis_d, hs_d, vs_d;

    assign tick       = (div == DIV_LAST);
    assign frame_wrap = tick && (h == H_LAST) && (v == V_LAST);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        in_range  = 1'b0;
        plot_addr = '0;
        visible   = 1'b0;
        hs_raw    = 1'b0;
        vs_raw    = 1'b0;
        in_range  = (pix.column < H_RES_C) && (pix.row < V_RES_C);
        // row*160 as two shifts; 15 bits hold the maximum of 19199.
        plot_addr = ({8'd0, pix.row} << 7) + ({8'd0, pix.row} << 5) + {7'd0, pix.column};
        visible   = (h < H_VIS_C) && (v < V_VIS_C);
        hs_raw    = (h >= H_SS_C) && (h <= H_SE_C);
        vs_raw    = (v >= V_SS_C) && (v <= V_SE_C);
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    // Write path: one registered stage, no back-pressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pix.plot && in_range;
            if (pix.plot && in_range) begin
                wr_addr <= plot_addr;
                wr_data <= pix.colour;
            end
        end
    end

    // Scan counters and the frame pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    // Read address and output pipeline. The address issued on one tick is
    // answered by the RAM well before the next tick (CLK_DIV >= 2), so the
    // delayed timing flags and rd_data describe the same pixel there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr     <= '0;
            vis_d       <= 1'b0;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            vga_blank_n <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (tick) begin
            if (visible) begin
                rd_addr <= ({5'd0, v[9:2]} << 7) + ({5'd0, v[9:2]} << 5) + {7'd0, h[9:2]};
            end
            vis_d       <= visible;
            hs_d        <= hs_raw;
            vs_d        <= vs_raw;
            vga_blank_n <= vis_d;
            vga_hs      <= ~hs_d;
            vga_vs      <= ~vs_d;
            if (vis_d) begin
                vga_r <= expand3(rd_data[8:6]);
                vga_g <= expand3(rd_data[5:3]);
                vga_b <= expand3(rd_data[2:0]);
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

`ifdef VGA_SINK_CLIP_CNT_EN
    logic clip_hit;
    assign clip_hit = pix.plot && !in_range;

    // A clip landing on the frame-wrap clk survives the clear as a count of 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clip_cnt <= '0;
        end else if (frame_wrap) begin
            clip_cnt <= clip_hit ? 8'd1 : 8'd0;
        end else if (clip_hit && (clip_cnt != 8'hFF)) begin
            clip_cnt <= clip_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_sink.sv
// tb_vga_frame_sink
//   Scoreboard bench for vga_frame_sink on a reduced raster (48x40 ticks,
//   32x32 visible) so whole frames fit in a short run. Writes and video
//   pixels are predicted into queues and popped as the DUT produces them.
module tb_vga_frame_sink;
    localparam int HV = 32, HSS = 36, HSE = 39, HT = 48;
    localparam int VV = 32, VSS = 34, VSE = 35, VT = 40;
    localparam int DIV = 2;
    localparam int FRAME_CLKS = HT * VT * DIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [14:0] wr_addr, rd_addr;
    logic [8:0]  wr_data, rd_data;
    logic        wr_en;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, frame_start;
`ifdef VGA_SINK_CLIP_CNT_EN
    logic [7:0]  clip_cnt;
`endif

    always #5 clk = ~clk;

    vga_frame_sink_if pix();

    vga_frame_sink #(
        .CLK_DIV(DIV),
        .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .resetn(resetn), .pix(pix),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .frame_start(frame_start)
`ifdef VGA_SINK_CLIP_CNT_EN
        , .clip_cnt(clip_cnt)
`endif
    );

    // External frame buffer: synchronous read, old data on collision.
    logic [8:0] mem [0:19199];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // c*73 is {c,c,c}; dropping the LSB gives the 8-bit channel.
    function automatic logic [7:0] ex3(input logic [2:0] c);
        int t;
        t = int'(c) * 73;
        return t[8:1];
    endfunction

    function automatic logic [31:0] exp_px(input int h, input int v);
        logic vis, hs_a, vs_a;
        logic [8:0] c;
        logic [23:0] rgb;
        vis  = (h < HV) && (v < VV);
        hs_a = (h >= HSS) && (h <= HSE);
        vs_a = (v >= VSS) && (v <= VSE);
        rgb  = '0;
        if (vis) begin
            c   = mem[(v / 4) * 160 + h / 4];
            rgb = {ex3(c[8:6]), ex3(c[5:3]), ex3(c[2:0])};
        end
        return {5'b0, vis, !hs_a, !vs_a, rgb};
    endfunction

    // ---------------- video scoreboard ----------------
    typedef struct { int h; int v; logic [31:0] px; } vid_t;
    vid_t vq[$];
    int   mh = 0, mv = 0, mdiv = 0;
    logic tick_edge = 1'b0, exp_fs = 1'b0;
    vid_t vin, vout;
    int   hs_lo = 0, vs_lo = 0;
    logic cnt_on = 1'b0;
    logic [31:0] vgot;

    always @(posedge clk) begin
        if (!resetn) begin
            mh <= 0; mv <= 0; mdiv <= 0;
            tick_edge <= 1'b0; exp_fs <= 1'b0;
            vq.delete();
        end else begin
            tick_edge <= (mdiv == DIV - 1);
            exp_fs    <= (mdiv == DIV - 1) && (mh == HT - 1) && (mv == VT - 1);
            if (mdiv == DIV - 1) begin
                vin.h = mh; vin.v = mv; vin.px = exp_px(mh, mv);
                vq.push_back(vin);
                mdiv <= 0;
                if (mh == HT - 1) begin
                    mh <= 0;
                    mv <= (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh <= mh + 1;
                end
            end else begin
                mdiv <= mdiv + 1;
            end
        end
    end

    // Outputs registered on a tick describe the pixel pushed one tick earlier.
    always @(negedge clk) begin
        if (resetn) begin
            check("frame_start", 32'(frame_start), 32'(exp_fs));
            if (tick_edge && vq.size() >= 2) begin
                vout = vq.pop_front();
                vgot = {5'b0, vga_blank_n, vga_hs, vga_vs, vga_r, vga_g, vga_b};
                check("video", vgot, vout.px);
                if (vout.h == 5 && vout.v == 5)
                    check("px161_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFF0092);
                if (vout.h == HV - 1 && vout.v == 0)
                    check("last_visible", 32'({vga_blank_n, vga_r, vga_g, vga_b}), 32'h1FFFFFF);
                if (vout.h == HV && vout.v == 0)
                    check("first_hblank", 32'({vga_blank_n, vga_r, vga_g, vga_b}), 32'h0);
                if (vout.h == 0 && vout.v == VV)
                    check("first_vblank", 32'({vga_blank_n, vga_r, vga_g, vga_b}), 32'h0);
                if (vout.h == 0 && vout.v == 0) begin
                    hs_lo = 0; vs_lo = 0; cnt_on = 1'b1;
                end
                if (!vga_hs) hs_lo++;
                if (!vga_vs) vs_lo++;
                if (cnt_on && vout.h == HT - 1 && vout.v == VT - 1) begin
                    check("hs_low_ticks", 32'(hs_lo), 32'(VT * (HSE - HSS + 1)));
                    check("vs_low_ticks", 32'(vs_lo), 32'(HT * (VSE - VSS + 1)));
                end
            end
        end
    end

    // ---------------- write scoreboard ----------------
    typedef struct { logic [14:0] a; logic [8:0] d; } wr_t;
    wr_t wq[$];
    wr_t win, wout;

    always @(posedge clk) begin
        if (resetn && pix.plot && pix.column < 160 && pix.row < 120) begin
            win.a = 15'(int'(pix.row) * 160 + int'(pix.column));
            win.d = pix.colour;
            wq.push_back(win);
        end
    end

    always @(negedge clk) begin
        if (resetn && wr_en) begin
            if (wq.size() == 0) begin
                check("wr_spurious", 32'(wr_en), 32'd0);
            end else begin
                wout = wq.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(wout.a));
                check("wr_data", 32'(wr_data), 32'(wout.d));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_plot(input int c, input int r, input logic [8:0] col);
        @(negedge clk);
        pix.plot = 1'b1; pix.column = 8'(c); pix.row = 7'(r); pix.colour = col;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        pix.plot = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_fs(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n <= 2 * FRAME_CLKS);
        if (!frame_start) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_en"},   32'(wr_en), 32'd0);
        check({tag, "_fs"},      32'(frame_start), 32'd0);
        check({tag, "_syncs"},   32'({vga_hs, vga_vs, vga_blank_n}), 32'b110);
        check({tag, "_rgb"},     32'({vga_r, vga_g, vga_b}), 32'd0);
        check({tag, "_addrs"},   32'({wr_addr, rd_addr}), 32'd0);
`ifdef VGA_SINK_CLIP_CNT_EN
        check({tag, "_clip"},    32'(clip_cnt), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic found;
        pix.plot = 1'b0; pix.column = '0; pix.row = '0; pix.colour = '0;
        for (int i = 0; i < 19200; i++) mem[i] = 9'h1FF;
        mem[0]   = 9'h000;
        mem[1]   = 9'h053;
        mem[3]   = 9'h124;
        mem[160] = 9'h0A5;
        mem[161] = 9'b111000100;

        repeat (3) @(negedge clk);
        check_reset("rst");
        resetn = 1'b1;

        // Corner write, then an out-of-range column.
        drive_plot(159, 119, 9'h1FF);
        drive_plot(160, 0, 9'h0AA);
        idle(1);
`ifdef VGA_SINK_CLIP_CNT_EN
        check("clip_one", 32'(clip_cnt), 32'd1);
`endif
        // Back-to-back burst outside the scanned window, with clips mixed in.
        drive_plot(10, 100, 9'h001);
        drive_plot(11, 100, 9'h002);
        drive_plot(0, 120, 9'h003);
        drive_plot(12, 100, 9'h004);
        drive_plot(255, 127, 9'h005);
        drive_plot(0, 119, 9'h106);
        drive_plot(100, 60, 9'h0F7);
        idle(2);
`ifdef VGA_SINK_CLIP_CNT_EN
        check("clip_three", 32'(clip_cnt), 32'd3);
`endif

        // Frame period, twice; the pixel scoreboard runs throughout.
        wait_fs("fs_sync", n);
        wait_fs("fs_period1", n);
        check("frame_period1", 32'(n), 32'(FRAME_CLKS));
        wait_fs("fs_period2", n);
        check("frame_period2", 32'(n), 32'(FRAME_CLKS));

        // Mid-frame asynchronous reset.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (mv == 20 && mh == 30) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_v20_h30", 32'(found), 32'd1);
        #1 resetn = 1'b0;
        #1 check_reset("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        wait_fs("fs_after_rst", n);
        check("rst_to_fs", 32'(n), 32'(FRAME_CLKS));

`ifdef VGA_SINK_CLIP_CNT_EN
        for (int i = 0; i < 300; i++) drive_plot(200, 5, 9'h000);
        idle(1);
        check("clip_sat", 32'(clip_cnt), 32'd255);
        wait_fs("fs_clip_clr", n);
        check("clip_clear", 32'(clip_cnt), 32'd0);
        // A clip on the very clk of the frame wrap.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (mdiv == DIV - 1 && mh == HT - 1 && mv == VT - 1) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_wrap", 32'(found), 32'd1);
        pix.plot = 1'b1; pix.column = 8'd170; pix.row = 7'd3;
        @(negedge clk);
        pix.plot = 1'b0;
        check("wrap_fs", 32'(frame_start), 32'd1);
        check("clip_clr_inc", 32'(clip_cnt), 32'd1);
`endif

        idle(4);
        check("wr_pending", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
